signal_edge_filter: RTL



---
 rtl/signal_edge_pkg.sv | 23 ++
 rtl/signal_edge_filter_chan.sv | 156 +++++++++++++++
 rtl/signal_edge_filter.sv | 55 +++++
 3 files changed

// File: rtl/signal_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signal_edge_pkg
// Desc     : Shared types and width helper for the signal edge filter.
// Revision : 1.0 - initial release
// ============================================================================

package signal_edge_pkg;

    typedef enum logic [1:0] {
        SEF_STABLE  = 2'd0,
        SEF_QUALIFY = 2'd1,
        SEF_DEAD    = 2'd2
    } sefState_t;

    // Bits needed to hold 0..maxVal, never less than one.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/signal_edge_filter_chan.sv
`default_nettype none
// ============================================================================
// Module   : signal_edge_filter_chan
// Desc     : One channel: stability qualifier, dead time, edge pulses and
//            optional accepted-rise counter (EDGE_COUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================

module signal_edge_filter_chan
    import signal_edge_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int DEADTIME   = 0
`ifdef EDGE_COUNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_sigIn,
    input  logic             i_enable,
    output logic             o_levelOut,
    output logic             o_risePulse,
    output logic             o_fallPulse
`ifdef EDGE_COUNT_EN
    ,
    input  logic             i_countClr,
    output logic [CNT_W-1:0] o_countOut
`endif
);

    localparam int STAB_W = cntWidth(FILTER_LEN);
    localparam int DEAD_W = cntWidth(DEADTIME);
    localparam logic [STAB_W-1:0] c_FILTER_LEN = STAB_W'(FILTER_LEN);
    localparam logic [DEAD_W-1:0] c_DEADTIME   = DEAD_W'(DEADTIME);

    sefState_t         r_state;
    sefState_t         w_stateNext;
    logic              r_lvl;
    logic              w_lvlNext;
    logic [STAB_W-1:0] r_stabCnt;
    logic [STAB_W-1:0] w_stabCntNext;
    logic [DEAD_W-1:0] r_deadCnt;
    logic [DEAD_W-1:0] w_deadCntNext;
    logic              r_rise;
    logic              w_riseNext;
    logic              r_fall;
    logic              w_fallNext;
    logic              w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= SEF_STABLE;
            r_lvl     <= 1'b0;
            r_stabCnt <= '0;
            r_deadCnt <= '0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_lvl     <= w_lvlNext;
            r_stabCnt <= w_stabCntNext;
            r_deadCnt <= w_deadCntNext;
            r_rise    <= w_riseNext;
            r_fall    <= w_fallNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_lvlNext     = r_lvl;
        w_stabCntNext = r_stabCnt;
        w_deadCntNext = r_deadCnt;
        w_riseNext    = 1'b0;
        w_fallNext    = 1'b0;
        w_accept      = 1'b0;

        case (r_state)
            SEF_STABLE: begin
                w_stabCntNext = '0;
                if (i_enable && (i_sigIn != r_lvl)) begin
                    if (FILTER_LEN == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_stateNext   = SEF_QUALIFY;
                        w_stabCntNext = STAB_W'(1);
                    end
                end
            end
            SEF_QUALIFY: begin
                if (!i_enable || (i_sigIn == r_lvl)) begin
                    w_stateNext   = SEF_STABLE;
                    w_stabCntNext = '0;
                end else if ((r_stabCnt + STAB_W'(1)) == c_FILTER_LEN) begin
                    w_accept = 1'b1;
                end else begin
                    w_stabCntNext = r_stabCnt + STAB_W'(1);
                end
            end
            SEF_DEAD: begin
                // Input is ignored and enable has no effect until expiry.
                if (r_deadCnt <= DEAD_W'(1)) begin
                    w_stateNext   = SEF_STABLE;
                    w_deadCntNext = '0;
                end else begin
                    w_deadCntNext = r_deadCnt - DEAD_W'(1);
                end
            end
            default: begin
                w_stateNext   = SEF_STABLE;
                w_stabCntNext = '0;
                w_deadCntNext = '0;
            end
        endcase

        if (w_accept) begin
            w_lvlNext     = i_sigIn;
            w_stabCntNext = '0;
            w_riseNext    = i_sigIn;
            w_fallNext    = ~i_sigIn;
            if (i_sigIn && (DEADTIME > 0)) begin
                w_stateNext   = SEF_DEAD;
                w_deadCntNext = c_DEADTIME;
            end else begin
                w_stateNext   = SEF_STABLE;
            end
        end
    end

    always_comb begin
        o_levelOut  = r_lvl;
        o_risePulse = r_rise;
        o_fallPulse = r_fall;
    end

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] r_evtCnt;

    // Clear wins over the old count, but a coincident rise still counts once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evtCnt <= '0;
        end else if (i_countClr) begin
            r_evtCnt <= w_riseNext ? CNT_W'(1) : '0;
        end else if (w_riseNext && !(&r_evtCnt)) begin
            r_evtCnt <= r_evtCnt + CNT_W'(1);
        end
    end

    assign o_countOut = r_evtCnt;
`endif

endmodule

`default_nettype wire

// File: rtl/signal_edge_filter.sv
`default_nettype none
// ============================================================================
// Module   : signal_edge_filter
// Desc     : N-channel glitch filter and edge detector; EDGE_COUNT_EN adds
//            per-channel accepted-rise counters.
// Revision : 1.0 - initial release
// ============================================================================

module signal_edge_filter #(
    parameter int N          = 1,
    parameter int FILTER_LEN = 4,
    parameter int DEADTIME   = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       sig_in,
    input  logic               enable,
    output logic [N-1:0]       level_out,
    output logic [N-1:0]       rise_pulse,
    output logic [N-1:0]       fall_pulse
`ifdef EDGE_COUNT_EN
    ,
    input  logic               count_clr,
    output logic [N*CNT_W-1:0] count_out
`endif
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        signal_edge_filter_chan #(
            .FILTER_LEN (FILTER_LEN),
            .DEADTIME   (DEADTIME)
`ifdef EDGE_COUNT_EN
            ,
            .CNT_W      (CNT_W)
`endif
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_sigIn     (sig_in[i]),
            .i_enable    (enable),
            .o_levelOut  (level_out[i]),
            .o_risePulse (rise_pulse[i]),
            .o_fallPulse (fall_pulse[i])
`ifdef EDGE_COUNT_EN
            ,
            .i_countClr  (count_clr),
            .o_countOut  (count_out[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

`default_nettype wire
